timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter PRESET_RST, default 32'd0: reset value of the PRESET register.
REQ-002 Parameter CTRL_RST, default 32'd0: reset value of the CTRL register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (clears state when 0, independent of clk).
REQ-005 addr  input  2  word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-006 we  input  1  write strobe from the CPU store path (bridge-decoded).
REQ-007 byte_en  input  4  byte lanes of the write; a lane is written only when its bit and we are both 1.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  read data for addr; feeds the CPU load-data path.
REQ-010 irq  output  1  interrupt request; drives one HWInt bit of the CPU.

Function
REQ-011 CTRL fields: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, others treated as 00), [3] IM (interrupt mask); other bits read 0.
REQ-012 rdata is combinational: CTRL, PRESET, COUNT, or 0 for addr 3.
REQ-013 Writes to COUNT and to addr 3 are ignored.
REQ-014 FSM states: IDLE, LOAD, CNT, INT.
REQ-015 IDLE: if EN=1, go to LOAD next cycle.
REQ-016 LOAD: COUNT <= PRESET; go to CNT.
REQ-017 CNT: if EN=0, go to IDLE with COUNT held; else if COUNT<=1 at a decrement tick, COUNT <= 0 and go to INT; else at a tick, COUNT <= COUNT-1.
REQ-018 INT: set the irq flag for one cycle; MODE 00 clears EN and goes to IDLE; MODE 01 goes to LOAD.
REQ-019 irq = flag AND IM; in MODE 00 the flag stays set until any CTRL write; in MODE 01 the flag is a one-cycle pulse.
REQ-020 Latency: with EN written at edge t, LOAD at t+1, CNT at t+2 with COUNT=PRESET, and irq at t+PRESET+2 for PRESET>=1; PRESET=0 raises irq at t+3.
REQ-021 A PRESET write during CNT does not affect the running count; it takes effect at the next LOAD.
REQ-022 If a CTRL write clearing EN coincides with terminal count, the write wins: go to IDLE, no flag set.
REQ-023 If a CTRL write coincides with INT, the write value is applied and the flag sets afterwards (flag set wins over clear).
REQ-024 COUNT underflow never occurs; COUNT saturates at 0.

Reset
REQ-025 While reset=0: state=IDLE, CTRL=CTRL_RST, PRESET=PRESET_RST, COUNT=0, flag=0, irq=0, prescale counter=0.
REQ-026 Reset asserted mid-count aborts immediately; no irq is produced after release until a new EN write.

Configuration
REQ-027 With TIMER_PRESCALE_EN defined, CTRL[7:4]=P and a decrement tick occurs once every P+1 cycles in CNT; the prescale counter clears on LOAD.
REQ-028 Without TIMER_PRESCALE_EN, CTRL[7:4] reads 0 and ignores writes, and every CNT cycle is a tick.

Structure
REQ-029 A shared package holds the state enum, the register word offsets, the CTRL bit positions and the MODE encodings.
REQ-030 The design is a single module with no sub-modules; the prescaler is inline.

Verification
REQ-031 Scenario 1 (one-shot): PRESET=5, then CTRL=0x9 at edge t -> COUNT 5,4,3,2,1 from t+2, irq=1 from t+7 and held, EN reads 0; a later CTRL=0x0 write drops irq.
REQ-032 Scenario 2 (auto-reload): PRESET=3, CTRL=0xB -> one-cycle irq pulses every 5 cycles for 4 periods.
REQ-033 Scenario 3 (mask and lanes): CTRL=0x1 (IM=0), PRESET=2 -> irq stays 0 while the state still passes INT; byte_en=0001 write of 0xFFFFFFFF to PRESET changes only PRESET[7:0].
REQ-034 Scenario 4 (collisions): CTRL=0x0 written exactly at the COUNT=1 tick -> no irq, state IDLE; PRESET rewritten to 100 mid-count -> current period unaffected.
REQ-035 Scenario 5 (reset and PRESET=0): reset pulsed low with COUNT=7 -> outputs at reset values asynchronously; PRESET=0 with EN -> irq at t+3.
REQ-036 Scenario 6 (TIMER_PRESCALE_EN): CTRL=0x19 (P=1), PRESET=2 -> COUNT changes every 2 cycles, irq at t+6.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// -----------------------------------------------------------------------------
// timer_counter_pkg
//   Shared definitions for the timer_counter block:
//     - state_t   : controller states (IDLE, LOAD, CNT, INT)
//     - ADDR_*    : register word offsets on the 2-bit addr bus
//     - CTRL_*    : bit positions of the CTRL fields
//     - mode_e    : MODE field encodings plus a decoder that folds the
//                   unused encodings onto one-shot
// -----------------------------------------------------------------------------
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Register word offsets
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_PSC_LSB  = 4;
  localparam int CTRL_PSC_MSB  = 7;
  localparam int CTRL_W        = CTRL_PSC_MSB + 1;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01
  } mode_e;

  // Encodings 10 and 11 behave as one-shot.
  function automatic mode_e decode_mode(input logic [1:0] field);
    return (field == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//   Memory-mapped down-counting timer with one-shot and auto-reload modes.
//   Registers: 0=CTRL (EN, MODE, IM, optional prescale P), 1=PRESET,
//   2=COUNT (read-only), 3=reserved (reads 0, writes ignored).
//
//   Optional feature macro: TIMER_PRESCALE_EN
//     defined   -> CTRL[7:4]=P, one decrement tick every P+1 cycles in CNT
//     undefined -> CTRL[7:4] reads 0, every CNT cycle is a tick
//
// Ports
//   clk      in   1  clock, rising edge
//   reset    in   1  asynchronous, active-low reset
//   addr     in   2  register word select
//   we       in   1  write strobe
//   byte_en  in   4  write byte lanes
//   wdata    in  32  write data
//   rdata    out 32  combinational read data for addr
//   irq      out  1  interrupt request (flag AND IM)
// -----------------------------------------------------------------------------
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'd0,
  parameter logic [31:0] CTRL_RST   = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

`ifdef TIMER_PRESCALE_EN
  localparam logic [CTRL_W-1:0] CTRL_MASK = '1;
`else
  localparam logic [CTRL_W-1:0] CTRL_MASK = CTRL_W'((1 << CTRL_PSC_LSB) - 1);
`endif

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [31:0]         preset_q, preset_d;
  logic [31:0]         count_q, count_d;
  logic                flag_q, flag_d;

  logic ctrl_wr;      // any CTRL write, regardless of lanes
  logic ctrl_lane0;   // CTRL write that actually lands on the field byte
  logic en_eff;       // EN as seen this cycle, a concurrent write taking priority
  logic one_shot;
  logic tick;
  logic term_set;     // terminal count reached: enter INT and raise the flag

  assign ctrl_wr    = we && (addr == ADDR_CTRL);
  assign ctrl_lane0 = ctrl_wr && byte_en[0];
  assign en_eff     = ctrl_lane0 ? wdata[CTRL_EN] : ctrl_q[CTRL_EN];
  assign one_shot   = (decode_mode(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]) == MODE_ONESHOT);

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
  logic [3:0] psc_q, psc_d;

  // >= rather than == so that lowering P mid-count never waits for a wrap.
  assign tick = (psc_q >= ctrl_q[CTRL_PSC_MSB:CTRL_PSC_LSB]);

  always_comb begin
    psc_d = psc_q;
    if (state_q == ST_LOAD) begin
      psc_d = '0;
    end else if (state_q == ST_CNT) begin
      psc_d = tick ? 4'd0 : psc_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) psc_q <= '0;
    else        psc_q <= psc_d;
  end
`else
  assign tick = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    term_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        // A write clearing EN wins over a coincident terminal count.
        if (!en_eff) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count_q <= 32'd1) begin
            count_d  = '0;
            state_d  = ST_INT;
            term_set = 1'b1;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
      end
      ST_INT: begin
        state_d = one_shot ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register writes and flag
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_lane0) begin
      ctrl_d = wdata[CTRL_W-1:0] & CTRL_MASK;
    end else if ((state_q == ST_INT) && one_shot) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
  end

  always_comb begin
    preset_d = preset_q;
    for (int b = 0; b < 4; b++) begin
      if (we && (addr == ADDR_PRESET) && byte_en[b]) begin
        preset_d[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // Setting the flag has priority over clearing it; in auto-reload mode the
  // flag is dropped as INT is left, giving a one-cycle pulse.
  always_comb begin
    flag_d = flag_q;
    if (term_set) begin
      flag_d = 1'b1;
    end else if (ctrl_wr || ((state_q == ST_INT) && !one_shot)) begin
      flag_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= CTRL_RST[CTRL_W-1:0] & CTRL_MASK;
      preset_q <= PRESET_RST;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_CTRL:   rdata = 32'(ctrl_q);
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      ADDR_RSVD:   rdata = '0;
      default:     rdata = '0;
    endcase
  end

  assign irq = flag_q && ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//   Self-checking bench for timer_counter: a table of register-access vectors
//   followed by hand-written multi-cycle sequences (one-shot, auto-reload,
//   masking, collisions, asynchronous reset, PRESET=0, optional prescaler).
// -----------------------------------------------------------------------------
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_RB_ALL = 32'h0000_00FE;
`else
  localparam logic [31:0] CTRL_RB_ALL = 32'h0000_000E;
`endif

  timer_counter dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .byte_en (byte_en),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic irq_check(input string name, input logic exp);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  // One write committed on the next rising edge; returns 1 ns after it.
  task automatic wr_be(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byte_en = be; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; byte_en = 4'b0000;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_be(a, d, 4'b1111);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, ADDR_PRESET, 4'b0001, 32'hFFFF_FFFF, ADDR_PRESET, 32'h0000_00FF};
    vecs[1]  = '{1'b1, ADDR_PRESET, 4'b0110, 32'h1234_5678, ADDR_PRESET, 32'h0034_56FF};
    vecs[2]  = '{1'b1, ADDR_PRESET, 4'b1000, 32'hAABB_CCDD, ADDR_PRESET, 32'hAA34_56FF};
    vecs[3]  = '{1'b1, ADDR_PRESET, 4'b0000, 32'h0000_0000, ADDR_PRESET, 32'hAA34_56FF};
    vecs[4]  = '{1'b0, ADDR_PRESET, 4'b1111, 32'h0000_0000, ADDR_PRESET, 32'hAA34_56FF};
    vecs[5]  = '{1'b1, ADDR_COUNT,  4'b1111, 32'hDEAD_BEEF, ADDR_COUNT,  32'h0000_0000};
    vecs[6]  = '{1'b1, ADDR_RSVD,   4'b1111, 32'hFFFF_FFFF, ADDR_RSVD,   32'h0000_0000};
    vecs[7]  = '{1'b1, ADDR_CTRL,   4'b1111, 32'hFFFF_FFFE, ADDR_CTRL,   CTRL_RB_ALL};
    vecs[8]  = '{1'b1, ADDR_CTRL,   4'b1110, 32'h0000_0000, ADDR_CTRL,   CTRL_RB_ALL};
    vecs[9]  = '{1'b1, ADDR_CTRL,   4'b0001, 32'h0000_0000, ADDR_CTRL,   32'h0000_0000};
    vecs[10] = '{1'b1, ADDR_PRESET, 4'b1111, 32'h0000_0005, ADDR_PRESET, 32'h0000_0005};

    reset = 1'b0; we = 1'b0; addr = ADDR_CTRL; byte_en = 4'b0000; wdata = '0;
    cyc(2);

    // Reset state
    rd_check("rst_ctrl",   ADDR_CTRL,   32'h0);
    rd_check("rst_preset", ADDR_PRESET, 32'h0);
    rd_check("rst_count",  ADDR_COUNT,  32'h0);
    irq_check("rst_irq", 1'b0);
    reset = 1'b1;
    cyc(1);

    // Register access table
    for (int i = 0; i < NV; i++) begin
      we = vecs[i].we; addr = vecs[i].addr; byte_en = vecs[i].be; wdata = vecs[i].wdata;
      @(posedge clk); #1;
      we = 1'b0; byte_en = 4'b0000;
      rd_check($sformatf("vec%0d_rdata", i), vecs[i].rd_addr, vecs[i].exp);
      irq_check($sformatf("vec%0d_irq", i), 1'b0);
    end

    // One-shot: PRESET=5, CTRL=0x9 at edge t
    wr(ADDR_PRESET, 32'd5);
    wr(ADDR_CTRL, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      rd_check($sformatf("s1_count_k%0d", k), ADDR_COUNT,
               (k < 2 || k >= 7) ? 32'd0 : 32'(7 - k));
      irq_check($sformatf("s1_irq_k%0d", k), k >= 7);
    end
    rd_check("s1_ctrl_en_cleared", ADDR_CTRL, 32'h8);
    wr(ADDR_CTRL, 32'h0);
    irq_check("s1_irq_dropped", 1'b0);

    // Auto-reload: PRESET=3, CTRL=0xB -> pulses at t+5, t+10, t+15, t+20
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'hB);
    addr = ADDR_COUNT;
    for (int k = 1; k <= 21; k++) begin
      cyc(1);
      irq_check($sformatf("s2_irq_k%0d", k), (k >= 5) && ((k % 5) == 0));
      if (k == 2 || k == 7) check($sformatf("s2_count_k%0d", k), rdata, 32'd3);
      if (k == 10)          check("s2_count_k10", rdata, 32'd0);
    end
    wr(ADDR_CTRL, 32'h0);
    cyc(2);
    irq_check("s2_stopped_irq", 1'b0);

    // Mask: IM=0, PRESET=2; the run still completes (EN auto-clears)
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      irq_check($sformatf("s3_masked_irq_k%0d", k), 1'b0);
    end
    rd_check("s3_ctrl_after_int", ADDR_CTRL, 32'h0);
    rd_check("s3_count_after_int", ADDR_COUNT, 32'h0);
    wr_be(ADDR_PRESET, 32'hFFFF_FFFF, 4'b0001);
    rd_check("s3_preset_lane0", ADDR_PRESET, 32'h0000_00FF);

    // Collision: EN cleared exactly at the COUNT=1 tick (IM kept set)
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'h9);
    cyc(4);
    rd_check("s4a_count_before", ADDR_COUNT, 32'd1);
    wr(ADDR_CTRL, 32'h8);
    irq_check("s4a_irq_at_collision", 1'b0);
    rd_check("s4a_count_held", ADDR_COUNT, 32'd1);
    cyc(5);
    irq_check("s4a_irq_later", 1'b0);
    rd_check("s4a_count_later", ADDR_COUNT, 32'd1);

    // PRESET rewritten mid-count: current period unaffected
    wr(ADDR_PRESET, 32'd4);
    wr(ADDR_CTRL, 32'h9);
    cyc(3);
    rd_check("s4b_count_k3", ADDR_COUNT, 32'd3);
    wr(ADDR_PRESET, 32'd100);
    rd_check("s4b_count_k4", ADDR_COUNT, 32'd2);
    cyc(1);
    irq_check("s4b_irq_k5", 1'b0);
    cyc(1);
    irq_check("s4b_irq_k6", 1'b1);
    rd_check("s4b_preset", ADDR_PRESET, 32'd100);
    cyc(1);
    rd_check("s4b_ctrl_k7", ADDR_CTRL, 32'h8);
    wr(ADDR_CTRL, 32'h9);
    irq_check("s4b_irq_cleared_by_write", 1'b0);
    cyc(1);
    cyc(1);
    rd_check("s4b_new_preset_loaded", ADDR_COUNT, 32'd100);
    wr(ADDR_CTRL, 32'h0);

    // CTRL write coinciding with entry to INT: write applied, flag still set
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    cyc(3);
    wr(ADDR_CTRL, 32'h9);
    irq_check("s4c_irq_set_wins", 1'b1);
    rd_check("s4c_ctrl_written", ADDR_CTRL, 32'h9);
    cyc(1);
    irq_check("s4c_irq_held", 1'b1);
    rd_check("s4c_ctrl_en_cleared", ADDR_CTRL, 32'h8);
    wr(ADDR_CTRL, 32'h0);

    // Asynchronous reset mid-count with COUNT=7
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    cyc(5);
    rd_check("s5_count_before_reset", ADDR_COUNT, 32'd7);
    #2;
    reset = 1'b0;
    rd_check("s5_async_count", ADDR_COUNT, 32'd0);
    rd_check("s5_async_ctrl", ADDR_CTRL, 32'd0);
    rd_check("s5_async_preset", ADDR_PRESET, 32'd0);
    irq_check("s5_async_irq", 1'b0);
    cyc(2);
    reset = 1'b1;
    cyc(15);
    irq_check("s5_no_irq_after_release", 1'b0);
    rd_check("s5_count_after_release", ADDR_COUNT, 32'd0);

    // PRESET=0: irq at t+3
    wr(ADDR_PRESET, 32'd0);
    wr(ADDR_CTRL, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      irq_check($sformatf("s5_p0_irq_k%0d", k), k == 3);
    end
    wr(ADDR_CTRL, 32'h0);
    irq_check("s5_p0_irq_cleared", 1'b0);

`ifdef TIMER_PRESCALE_EN
    // Prescaler P=1, PRESET=2: COUNT changes every 2 cycles, irq at t+6
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h19);
    addr = ADDR_COUNT;
    for (int k = 2; k <= 7; k++) begin
      if (k == 2) cyc(2); else cyc(1);
      check($sformatf("s6_count_k%0d", k), rdata,
            (k <= 3) ? 32'd2 : (k <= 5) ? 32'd1 : 32'd0);
      irq_check($sformatf("s6_irq_k%0d", k), k >= 6);
    end
    wr(ADDR_CTRL, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
